rca_result_acc: RTL and testbench

RCA_RESULT_ACC -- requirements
Module: rca_result_acc

---
 rtl/rca_result_acc.sv | 149 ++++++++++++++
 tb/tb_rca_result_acc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_result_acc.sv
// Accumulates OP_COUNT adder results ({cout,sum}) per run and presents the total with a sticky overflow flag.
// Optional macro RCA_ACC_SAT_EN: saturate the accumulator at 2^ACC_W-1 instead of wrapping.
module rca_result_acc #(
    parameter int OP_COUNT = 4,
    parameter int ACC_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [2:0]       sum,
    input  logic             cout,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(OP_COUNT);

    state_t           state_r;
    state_t           state_nx_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nx_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nx_s;
    logic             ovf_r;
    logic             ovf_nx_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             xfer_s;
    logic [ACC_W:0]   operand_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_add_s;

    assign operand_s = {{(ACC_W-3){1'b0}}, cout, sum};
    assign sum_s     = {1'b0, acc_r} + operand_s;
    // in_ready_r mirrors state_r == ACCUM, so it doubles as the transfer qualifier.
    assign xfer_s    = in_valid & in_ready_r;

    // Wrapped or saturated result of the current addition.
    always_comb begin
`ifdef RCA_ACC_SAT_EN
        if (sum_s[ACC_W]) begin
            acc_add_s = {ACC_W{1'b1}};
        end else begin
            acc_add_s = sum_s[ACC_W-1:0];
        end
`else
        acc_add_s = sum_s[ACC_W-1:0];
`endif
    end

    // Next-state and datapath update; clear overrides everything else.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        cnt_nx_s   = cnt_r;
        ovf_nx_s   = ovf_r;
        if (clear) begin
            state_nx_s = IDLE;
            acc_nx_s   = {ACC_W{1'b0}};
            cnt_nx_s   = 4'd0;
            ovf_nx_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nx_s = ACCUM;
                        acc_nx_s   = {ACC_W{1'b0}};
                        cnt_nx_s   = 4'd0;
                        ovf_nx_s   = 1'b0;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (xfer_s) begin
                        acc_nx_s = acc_add_s;
                        cnt_nx_s = cnt_r + 4'd1;
                        if (sum_s[ACC_W]) begin
                            ovf_nx_s = 1'b1;
                        end else begin
                            ovf_nx_s = ovf_r;
                        end
                        if (cnt_nx_s == LAST_CNT) begin
                            state_nx_s = DONE;
                        end else begin
                            state_nx_s = ACCUM;
                        end
                    end else begin
                        state_nx_s = ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = DONE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    acc_nx_s   = {ACC_W{1'b0}};
                    cnt_nx_s   = 4'd0;
                    ovf_nx_s   = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= 4'd0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            acc_r       <= acc_nx_s;
            cnt_r       <= cnt_nx_s;
            ovf_r       <= ovf_nx_s;
            in_ready_r  <= (state_nx_s == ACCUM);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s == ACCUM) || (state_nx_s == DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_acc   = acc_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_rca_result_acc.sv
// Self-checking bench for rca_result_acc: directed scenarios plus randomized runs against a plain-arithmetic model.
module tb_rca_result_acc;

    localparam int ACC_W = 6;
    localparam int MAXV  = 63;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic       in_valid;
    logic [2:0] sum;
    logic       cout;
    logic       out_ready;

    logic             in_ready, out_valid, out_ovf, busy;
    logic [ACC_W-1:0] out_acc;
    logic             in_ready5, out_valid5, out_ovf5, busy5;
    logic [ACC_W-1:0] out_acc5;

    logic [9:0] obs;
    logic [9:0] obs5;
    logic [9:0] exp_v;

    int tests_run;
    int tests_failed;

    assign obs  = {out_valid, in_ready, busy, out_ovf, out_acc};
    assign obs5 = {out_valid5, in_ready5, busy5, out_ovf5, out_acc5};

    rca_result_acc #(.OP_COUNT(4), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .sum(sum), .cout(cout), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .busy(busy)
    );

    rca_result_acc #(.OP_COUNT(5), .ACC_W(ACC_W)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .sum(sum), .cout(cout), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_ready(out_ready), .out_acc(out_acc5),
        .out_ovf(out_ovf5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: add an operand to the running total, flag overflow, wrap or saturate.
    task automatic model_add(inout int m_acc, inout logic m_ovf, input int op);
        int total;
        total = m_acc + op;
        if (total > MAXV) m_ovf = 1'b1;
`ifdef RCA_ACC_SAT_EN
        m_acc = (total > MAXV) ? MAXV : total;
`else
        m_acc = total % (MAXV + 1);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        {cout, sum} = 4'd0; out_ready = 1'b0;
        #3;
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got %b expected %b", obs, 10'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b expected %b", obs, 10'd0);
        end
    endtask

    task automatic test_basic();
        start = 1'b1; step(); start = 1'b0;
        tests_run++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 6'd0}) begin
            tests_failed++;
            $display("FAIL basic_start: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; {cout, sum} = 4'd15;
            step();
            in_valid = 1'b0;
            if (i < 3) begin
                exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 6'(15 * (i + 1))};
            end else begin
                exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 6'd60};
            end
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL basic_xfer%0d: got %b expected %b", i, obs, exp_v);
            end
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        tests_run++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 6'd60}) begin
            tests_failed++;
            $display("FAIL basic_idle_hold: got %b expected %b", obs, {1'b0, 1'b0, 1'b0, 1'b0, 6'd60});
        end
    endtask

    task automatic test_op5_overflow();
        int   m_acc;
        logic m_ovf;
        m_acc = 0; m_ovf = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; {cout, sum} = 4'd15;
            step();
            model_add(m_acc, m_ovf, 15);
        end
        in_valid = 1'b0;
`ifdef RCA_ACC_SAT_EN
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 6'd63};
`else
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 6'd11};
`endif
        tests_run++;
        if (obs5 !== exp_v) begin
            tests_failed++;
            $display("FAIL op5_done: got %b expected %b", obs5, exp_v);
        end
        tests_run++;
        if (obs5[6:0] !== {m_ovf, 6'(m_acc)}) begin
            tests_failed++;
            $display("FAIL op5_model: got %b expected %b", obs5[6:0], {m_ovf, 6'(m_acc)});
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        exp_v[9:7] = 3'b000;
        tests_run++;
        if (obs5 !== exp_v) begin
            tests_failed++;
            $display("FAIL op5_sticky_idle: got %b expected %b", obs5, exp_v);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ops [4];
        int         part;
        ops = '{4'd3, 4'd5, 4'd2, 4'd1};
        part = 0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0; {cout, sum} = 4'd9;
            step();
            exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 6'(part)};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL bp_gap%0d: got %b expected %b", i, obs, exp_v);
            end
            in_valid = 1'b1; {cout, sum} = ops[i];
            step();
            in_valid = 1'b0;
            part = part + int'(ops[i]);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 6'd11}) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got %b expected %b", k, obs, {1'b1, 1'b0, 1'b1, 1'b0, 6'd11});
            end
            step();
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        tests_run++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 6'd11}) begin
            tests_failed++;
            $display("FAIL bp_release: got %b expected %b", obs, {1'b0, 1'b0, 1'b0, 1'b0, 6'd11});
        end
    endtask

    task automatic test_clear();
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; {cout, sum} = 4'd7; step();
        {cout, sum} = 4'd9; step();
        {cout, sum} = 4'd4; clear = 1'b1; step();
        clear = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL clear_abort: got %b expected %b", obs, 10'd0);
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; {cout, sum} = 4'($urandom_range(0, 15));
            step();
            tests_run++;
            if (obs !== 10'd0) begin
                tests_failed++;
                $display("FAIL clear_idle%0d: got %b expected %b", k, obs, 10'd0);
            end
        end
        in_valid = 1'b0;
        start = 1'b1; clear = 1'b1; step(); start = 1'b0; clear = 1'b0;
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL clear_beats_start: got %b expected %b", obs, 10'd0);
        end
    endtask

    task automatic test_midrun_reset();
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; {cout, sum} = 4'd5; step(); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== 10'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got %b expected %b", obs, 10'd0);
        end
        step();
        rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        tests_run++;
        if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 6'd0}) begin
            tests_failed++;
            $display("FAIL post_reset_start: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; {cout, sum} = 4'd1; step();
        end
        in_valid = 1'b0;
        tests_run++;
        if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 6'd4}) begin
            tests_failed++;
            $display("FAIL post_reset_run: got %b expected %b", obs, {1'b1, 1'b0, 1'b1, 1'b0, 6'd4});
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        int   m_acc;
        logic m_ovf;
        int   cnt;
        int   budget;
        int   op;
        logic iv;
        for (int run = 0; run < 20; run++) begin
            m_acc = 0; m_ovf = 1'b0; cnt = 0; budget = 0;
            start = 1'b1; step(); start = 1'b0;
            tests_run++;
            if (obs !== {1'b0, 1'b1, 1'b1, 1'b0, 6'd0}) begin
                tests_failed++;
                $display("FAIL rnd_start%0d: got %b expected %b", run, obs, {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
            end
            while (cnt < 4 && budget < 200) begin
                iv = 1'($urandom_range(0, 1));
                op = int'($urandom_range(0, 15));
                in_valid = iv; {cout, sum} = 4'(op);
                start = ($urandom_range(0, 3) == 0);
                step();
                budget++;
                in_valid = 1'b0; start = 1'b0;
                if (iv) begin
                    model_add(m_acc, m_ovf, op);
                    cnt++;
                end
                if (cnt < 4) exp_v = {1'b0, 1'b1, 1'b1, m_ovf, 6'(m_acc)};
                else         exp_v = {1'b1, 1'b0, 1'b1, m_ovf, 6'(m_acc)};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL rnd_accum%0d: got %b expected %b", run, obs, exp_v);
                end
            end
            if (budget >= 200) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rnd_budget%0d: got %0d transfers expected 4", run, cnt);
            end
            exp_v = {1'b1, 1'b0, 1'b1, m_ovf, 6'(m_acc)};
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                step();
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL rnd_done_hold%0d: got %b expected %b", run, obs, exp_v);
                end
            end
            out_ready = 1'b1; step(); out_ready = 1'b0;
            exp_v = {1'b0, 1'b0, 1'b0, m_ovf, 6'(m_acc)};
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL rnd_idle%0d: got %b expected %b", run, obs, exp_v);
                end
                in_valid = 1'($urandom_range(0, 1)); {cout, sum} = 4'($urandom_range(0, 15));
                step();
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_op5_overflow();
        test_backpressure();
        test_clear();
        test_midrun_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
